seq_mult16: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/seq_mult16_csa.sv | 41 ++++
 rtl/seq_mult16.sv | 152 +++++++++++++++
 tb/tb_seq_mult16.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants and types for the seq_mult16 sequential multiplier.
//   MULT_W : operand width (16)
//   CNT_W  : step counter width (5, enough to hold 0..16)
//   state_t: controller states IDLE / RUN / DONE
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_W = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/seq_mult16_csa.sv
// ---------------------------------------------------------------------------
// seq_mult16_csa
// 16-bit carry-select adder built from four 4-bit blocks. Each block
// precomputes its sum for carry-in 0 and 1. The real block carry then
// selects one of the two results.
// Ports:
//   a_i, b_i : 16-bit addends
//   cin_i    : carry in
//   sum_o    : 16-bit sum
//   cout_o   : carry out of bit 15
// ---------------------------------------------------------------------------
module seq_mult16_csa
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a_i,
  input  logic [MULT_W-1:0] b_i,
  input  logic              cin_i,
  output logic [MULT_W-1:0] sum_o,
  output logic              cout_o
);

  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] r0;
    logic [4:0] r1;

    // r0 is the block sum with carry-in 0. r1 is the block sum with
    // carry-in 1. The maximum value is 15+15+1 = 31, which fits in 5 bits.
    assign r0 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
    assign r1 = r0 + 5'd1;

    assign sum_o[4*g +: 4] = carry[g] ? r1[3:0] : r0[3:0];
    assign carry[g+1]      = carry[g] ? r1[4]   : r0[4];
  end

  assign cout_o = carry[4];

endmodule : seq_mult16_csa

// File: rtl/seq_mult16.sv
// ---------------------------------------------------------------------------
// seq_mult16
// Unsigned 16x16 -> 32 shift-and-add multiplier. It performs one partial
// product step per clock.
//
// Optional feature (macro SEQ_MULT_EARLY_EXIT_EN):
//   When the macro is defined, RUN ends as soon as the remaining multiplier
//   bits are all zero. The outstanding right shifts are applied in that
//   same cycle. The product is identical in both builds.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request pulse, honoured only in IDLE or DONE
//   a       : multiplicand, captured when start is accepted
//   b       : multiplier, captured when start is accepted
//   busy    : high while in RUN
//   done    : one-cycle pulse in DONE
//   product : result; valid from DONE, held until the next accepted start
//   state_o : current controller state (debug visibility)
//
// Handshake: start is a request, and the DUT has no ready signal. A start
// seen in IDLE or DONE is taken on that clock edge. A start seen in RUN is
// dropped. done marks the single cycle in which the new product is first
// presented.
// ---------------------------------------------------------------------------
module seq_mult16
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MULT_W-1:0]   a,
  input  logic [MULT_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*MULT_W-1:0] product,
  output logic [1:0]          state_o
);

  state_t                state_q, state_d;
  logic [MULT_W-1:0]     m_q, m_d;
  logic [2*MULT_W-1:0]   p_q, p_d;
  logic [2*MULT_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [MULT_W-1:0]     add_sum;
  logic                  add_cout;
  logic [2*MULT_W-1:0]   p_step;
  logic [2*MULT_W-1:0]   p_run;
  logic                  last_step;

  // The upper half of P accumulates the partial product, and the
  // multiplicand is added to it.
  seq_mult16_csa u_csa (
    .a_i    (p_q[2*MULT_W-1:MULT_W]),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // One shift-and-add step. The adder carry becomes the new MSB, so no
  // bit of the sum is lost.
  always_comb begin
    p_step = {1'b0, p_q[2*MULT_W-1:MULT_W], p_q[MULT_W-1:1]};
    if (p_q[0]) begin
      p_step = {add_cout, add_sum, p_q[MULT_W-1:1]};
    end
  end

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // After the step taken at count cnt_q, the unconsumed multiplier bits are
  // the low (15 - cnt_q) bits of p_step. If they are all zero, the only work
  // left is (15 - cnt_q) right shifts, so apply them all in this cycle.
  // At cnt_q == 15 the mask is empty and the shift amount is zero, which
  // covers the normal final step.
  logic [MULT_W-1:0] rem_mask;
  logic              rem_zero;

  always_comb begin
    rem_mask  = 16'h7FFF >> cnt_q;
    rem_zero  = ((p_step[MULT_W-1:0] & rem_mask) == '0);
    last_step = rem_zero;
    p_run     = p_step;
    if (rem_zero) begin
      p_run = p_step >> (5'd15 - cnt_q);
    end
  end
`else
  always_comb begin
    p_run     = p_step;
    last_step = (cnt_q == 5'd15);
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start) begin
          m_d     = a;
          p_d     = {16'h0000, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d    = p_run;
        prod_d = p_run;
        cnt_d  = cnt_q + 5'd1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;
  assign state_o = state_q;

endmodule : seq_mult16

// File: tb/tb_seq_mult16.sv
// ---------------------------------------------------------------------------
// tb_seq_mult16
// Self-checking bench for seq_mult16. The bench drives and samples on the
// falling clock edge. Expected products come from plain a*b. Expected RUN
// lengths come from the position of the highest set bit of b.
// Define SEQ_MULT_EARLY_EXIT_EN for both the bench and the RTL to check the
// early-exit build.
// ---------------------------------------------------------------------------
module tb_seq_mult16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [1:0]  state_o;

  int n_vec;
  int n_err;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  seq_mult16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product),
    .state_o (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  function automatic int ref_lat(input logic [15:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
`else
    return 16;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // The caller is at a falling edge. This task presents start with the
  // operands for one clock and returns at the first RUN cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    a_i   = a;
    b_i   = b;
    exp_q.push_back(ref_mult(a, b));
    lat_q.push_back(ref_lat(b));
    @(negedge clk);
    start = 1'b0;
    a_i   = 16'($urandom);
    b_i   = 16'($urandom);
  endtask

  // This task counts RUN cycles until busy drops, then checks the DONE
  // cycle. If restart_at > 0, it pulses start with junk operands in that
  // RUN cycle. The task returns at the falling edge of the DONE cycle.
  task automatic wait_done(input string tag, input int restart_at);
    int          cycles;
    logic [31:0] exp_p;
    int          exp_l;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (cycles == restart_at) begin
        start = 1'b1;
        a_i   = 16'($urandom);
        b_i   = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_p = 32'hDEAD_BEEF;
    exp_l = -1;
    if (exp_q.size() > 0) exp_p = exp_q.pop_front();
    if (lat_q.size() > 0) exp_l = lat_q.pop_front();
    check({tag, ".cycles"},  32'(cycles), 32'(exp_l));
    check({tag, ".done"},    32'(done),   32'd1);
    check({tag, ".product"}, product,     exp_p);
  endtask

  // This task checks the cycle after DONE when no new start is given. It
  // expects done and busy to be low, the state to be IDLE, and the product
  // to be held.
  task automatic check_idle_after(input string tag);
    logic [31:0] held;
    held = product;
    @(negedge clk);
    check({tag, ".done_low"}, 32'(done),    32'd0);
    check({tag, ".busy_low"}, 32'(busy),    32'd0);
    check({tag, ".idle"},     32'(state_o), 32'd0);
    check({tag, ".held"},     product,      held);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    a_i   = 16'h0;
    b_i   = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy",    32'(busy),    32'd0);
    check("rst.done",    32'(done),    32'd0);
    check("rst.product", product,      32'h0);
    check("rst.state",   32'(state_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 * 5
    start_op(16'd3, 16'd5);
    check("d35.busy", 32'(busy), 32'd1);
    wait_done("d35", 0);
    check("d35.value", product, 32'h0000_000F);
    check_idle_after("d35");

    // All-ones operands take the carry-out path on every step.
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("ffff", 0);
    check("ffff.value", product, 32'hFFFE_0001);
    check_idle_after("ffff");

    // A start in RUN cycle 5 must be ignored.
    start_op(16'h1357, 16'h8ACE);
    wait_done("restart", 5);
    check_idle_after("restart");

    // Reset in RUN cycle 8 aborts the operation.
    start_op(16'hABCD, 16'h9001);
    repeat (7) @(negedge clk);
    check("abort.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.product", product,      32'h0);
    check("abort.busy",    32'(busy),    32'd0);
    check("abort.done",    32'(done),    32'd0);
    check("abort.state",   32'(state_o), 32'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort.no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'd7, 16'd6);
    wait_done("post_rst", 0);
    check("post_rst.value", product, 32'h0000_002A);
    check_idle_after("post_rst");

    // Back to back: start is held in the DONE cycle.
    start_op(16'd11, 16'd13);
    wait_done("b2b_first", 0);
    start_op(16'd2, 16'd9);
    check("b2b.busy", 32'(busy), 32'd1);
    wait_done("b2b_second", 0);
    check("b2b.value", product, 32'h0000_0012);
    check_idle_after("b2b");

    // Early-exit corner operands. These are checked in both builds, and only
    // the latency expectation differs between the two.
    start_op(16'h1234, 16'h0001);
    wait_done("b1", 0);
    check("b1.value", product, 32'h0000_1234);
    start_op(16'hBEEF, 16'h0000);
    wait_done("b0", 0);
    check("b0.value", product, 32'h0);
    start_op(16'hFFFF, 16'h8000);
    wait_done("bmsb", 0);
    check("bmsb.value", product, 32'h7FFF_8000);
    check_idle_after("corner");

    // Random operations with random gaps and random back-to-back starts.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      // Keep some multipliers short so the early-exit lengths vary.
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 15);
      start_op(ra, rb);
      wait_done("rand", 0);
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    check_idle_after("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_mult16
